memory_access: RTL and testbench

- MIPS MEM stage. Sits directly downstream of the execute stage and consumes its EX/MEM outputs.
- Holds the data memory and performs byte/half/word loads and stores.
- Resolves the branch decision back to fetch.
- Registers the MEM/WB pipeline latch that feeds writeback and the second forwarding path.

---
 rtl/mips_pkg.sv | 40 ++++
 rtl/memory_access_if.sv | 38 +++
 rtl/data_memory.sv | 25 ++
 rtl/memory_access.sv | 113 +++++++++++
 tb/tb_memory_access.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: MEM/WB control bus field positions, access size codes,
// and the decoded MEM control struct.
package mips_pkg;
  localparam int MEM_READ     = 0;
  localparam int MEM_WRITE    = 1;
  localparam int MEM_SIZE_LO  = 2;
  localparam int MEM_SIZE_HI  = 3;
  localparam int MEM_UNSIGNED = 4;
  localparam int MEM_BEQ      = 5;
  localparam int MEM_BNE      = 6;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam int WB_REG_WRITE  = 0;
  localparam int WB_MEM_TO_REG = 1;

  localparam int NUM_LANES = 4;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [1:0] size;
    logic       unsgn;
    logic       beq;
    logic       bne;
  } mem_ctrl_t;

  function automatic mem_ctrl_t decode_mem(input logic [MEM_BNE:0] b);
    mem_ctrl_t c;
    c.rd    = b[MEM_READ];
    c.wr    = b[MEM_WRITE];
    c.size  = b[MEM_SIZE_HI:MEM_SIZE_LO];
    c.unsgn = b[MEM_UNSIGNED];
    c.beq   = b[MEM_BEQ];
    c.bne   = b[MEM_BNE];
    return c;
  endfunction
endpackage

// File: rtl/memory_access_if.sv
// EX/MEM inputs and MEM/WB outputs of the MEM stage, bundled as one bus.
interface memory_access_if #(
  parameter int len         = 32,
  parameter int NB          = $clog2(len),
  parameter int len_mem_bus = 9,
  parameter int len_wb_bus  = 2
);
  logic [len-1:0]         in_alu;
  logic [len-1:0]         in_reg2;
  logic                   in_zero_flag;
  logic [len-1:0]         in_pc_branch;
  logic [NB-1:0]          in_write_reg;
  logic [len_mem_bus-1:0] memory_bus;
  logic [len_wb_bus-1:0]  writeBack_bus;
  logic                   in_halt_flag;

  logic                   out_pc_src;
  logic [len-1:0]         out_pc_branch;
  logic [len-1:0]         out_mem_data;
  logic [len-1:0]         out_alu;
  logic [NB-1:0]          out_write_reg;
  logic [len_wb_bus-1:0]  writeBack_bus_out;
  logic                   out_halt_flag;

  modport master (
    output in_alu, in_reg2, in_zero_flag, in_pc_branch, in_write_reg,
           memory_bus, writeBack_bus, in_halt_flag,
    input  out_pc_src, out_pc_branch, out_mem_data, out_alu, out_write_reg,
           writeBack_bus_out, out_halt_flag
  );

  modport slave (
    input  in_alu, in_reg2, in_zero_flag, in_pc_branch, in_write_reg,
           memory_bus, writeBack_bus, in_halt_flag,
    output out_pc_src, out_pc_branch, out_mem_data, out_alu, out_write_reg,
           writeBack_bus_out, out_halt_flag
  );
endinterface

// File: rtl/data_memory.sv
// Byte-lane data RAM: one bank per lane, shared async read, async debug read, sync write.
module data_memory #(
  parameter int ram_depth = 1024,
  parameter int NA        = $clog2(ram_depth),
  parameter int NUM_LANES = 4
) (
  input  logic                         clk,
  input  logic [NA-1:0]                addr,
  input  logic [NUM_LANES-1:0]         we,
  input  logic [NUM_LANES-1:0][7:0]    wdata,
  output logic [NUM_LANES-1:0][7:0]    rdata,
  input  logic [NA-1:0]                debug_addr,
  output logic [NUM_LANES-1:0][7:0]    debug_data
);
  // Separate arrays per lane keep each bank single-driven and map to byte-enable RAM.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [7:0] bank [ram_depth];

    always_ff @(posedge clk)
      if (we[l]) bank[addr] <= wdata[l];

    assign rdata[l]      = bank[addr];
    assign debug_data[l] = bank[debug_addr];
  end
endmodule

// File: rtl/memory_access.sv
// MIPS MEM stage: data memory access with lane steering and load extension,
// branch resolution, and the MEM/WB pipeline register.
module memory_access
  import mips_pkg::*;
#(
  parameter int len         = 32,
  parameter int NB          = $clog2(len),
  parameter int len_mem_bus = 9,
  parameter int len_wb_bus  = 2,
  parameter int ram_depth   = 1024,
  parameter int NA          = $clog2(ram_depth)
) (
  input  logic            clk,
  input  logic            reset,
  memory_access_if.slave  bus,
  input  logic [NA-1:0]   debug_addr,
  output logic [len-1:0]  debug_data
);
  logic [len_mem_bus-1:0]        mem_bus;
  mem_ctrl_t                     ctrl;
  logic [NA-1:0]                 word_addr;
  logic [1:0]                    off;
  logic [NUM_LANES-1:0]          we;
  logic [NUM_LANES-1:0][7:0]     wdata;
  logic [NUM_LANES-1:0][7:0]     rword;
  logic [NUM_LANES-1:0][7:0]     dword;
  logic [7:0]                    ld_byte;
  logic [15:0]                   ld_half;
  logic [len-1:0]                load_val;

  logic [len-1:0]        mem_data_q;
  logic [len-1:0]        alu_q;
  logic [NB-1:0]         write_reg_q;
  logic [len_wb_bus-1:0] wb_q;
  logic                  halt_q;

  assign mem_bus   = bus.memory_bus;
  assign ctrl      = decode_mem(mem_bus[MEM_BNE:0]);
  assign word_addr = bus.in_alu[NA+1:2];
  assign off       = bus.in_alu[1:0];

  // Upper address bits wrap; reserved control bits are ignored.
  logic unused_bits;
  assign unused_bits = ^{bus.in_alu[len-1:NA+2], mem_bus[len_mem_bus-1:MEM_BNE+1]};

  assign bus.out_pc_src    = (ctrl.beq & bus.in_zero_flag) | (ctrl.bne & ~bus.in_zero_flag);
  assign bus.out_pc_branch = bus.in_pc_branch;

  always_comb begin
    we    = '0;
    wdata = bus.in_reg2;
    case (ctrl.size)
      SZ_BYTE: begin
        we[off] = 1'b1;
        wdata   = {NUM_LANES{bus.in_reg2[7:0]}};
      end
      SZ_HALF: begin
        we[{off[1], 1'b0}] = 1'b1;
        we[{off[1], 1'b1}] = 1'b1;
        wdata = {2{bus.in_reg2[15:0]}};
      end
      default: we = '1;
    endcase
    if (!ctrl.wr || reset) we = '0;
  end

  data_memory #(.ram_depth(ram_depth), .NA(NA), .NUM_LANES(NUM_LANES)) u_dmem (
    .clk        (clk),
    .addr       (word_addr),
    .we         (we),
    .wdata      (wdata),
    .rdata      (rword),
    .debug_addr (debug_addr),
    .debug_data (dword)
  );
  assign debug_data = dword;

  assign ld_byte = rword[off];
  assign ld_half = {rword[{off[1], 1'b1}], rword[{off[1], 1'b0}]};

  always_comb begin
    case (ctrl.size)
      SZ_BYTE: load_val = ctrl.unsgn ? {{(len-8){1'b0}}, ld_byte}
                                     : {{(len-8){ld_byte[7]}}, ld_byte};
      SZ_HALF: load_val = ctrl.unsgn ? {{(len-16){1'b0}}, ld_half}
                                     : {{(len-16){ld_half[15]}}, ld_half};
      default: load_val = rword;
    endcase
    if (!ctrl.rd) load_val = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_data_q  <= '0;
      alu_q       <= '0;
      write_reg_q <= '0;
      wb_q        <= '0;
      halt_q      <= 1'b0;
    end else begin
      mem_data_q  <= load_val;
      alu_q       <= bus.in_alu;
      write_reg_q <= bus.in_write_reg;
      wb_q        <= bus.writeBack_bus;
      halt_q      <= bus.in_halt_flag;
    end
  end

  assign bus.out_mem_data      = mem_data_q;
  assign bus.out_alu           = alu_q;
  assign bus.out_write_reg     = write_reg_q;
  assign bus.writeBack_bus_out = wb_q;
  assign bus.out_halt_flag     = halt_q;
endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: byte-addressed reference memory, directed
// test-plan steps, then randomized traffic.
module tb_memory_access;
  localparam int LEN = 32, NB = 5, LM = 9, LW = 2, DEPTH = 1024, NA = 10;
  localparam int WORDS = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [NA-1:0]   debug_addr;
  logic [LEN-1:0]  debug_data;

  memory_access_if #(.len(LEN), .NB(NB), .len_mem_bus(LM), .len_wb_bus(LW)) bus ();

  memory_access #(.len(LEN), .NB(NB), .len_mem_bus(LM), .len_wb_bus(LW),
                  .ram_depth(DEPTH), .NA(NA)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .debug_addr (debug_addr),
    .debug_data (debug_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mem_data;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic [1:0]  wb;
    logic        halt;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] model_mem [DEPTH*4];
  int         total = 0;
  int         bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Load by byte address: gather the bytes of the naturally aligned unit, then extend.
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    int base, n;
    logic [31:0] v;
    base = int'(a % (DEPTH*4));
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    base = base - (base % n);
    v = 0;
    for (int i = 0; i < n; i++) v = v | (32'(model_mem[base+i]) << (8*i));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    int base, n;
    base = int'(a % (DEPTH*4));
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    base = base - (base % n);
    for (int i = 0; i < n; i++) model_mem[base+i] = d[8*i +: 8];
  endtask

  // One instruction per cycle: drive, check the combinational outputs, queue the registered ones.
  task automatic drive(input logic rst, input logic [31:0] alu, input logic [31:0] reg2,
                       input logic [8:0] mb, input logic [1:0] wb, input logic [4:0] wreg,
                       input logic halt, input logic zero, input logic [31:0] pcb,
                       input logic [NA-1:0] dbg);
    exp_t e;
    logic exp_pc;
    @(negedge clk);
    reset = rst;
    bus.in_alu = alu;  bus.in_reg2 = reg2;  bus.memory_bus = mb;
    bus.writeBack_bus = wb;  bus.in_write_reg = wreg;  bus.in_halt_flag = halt;
    bus.in_zero_flag = zero;  bus.in_pc_branch = pcb;  debug_addr = dbg;
    #1;
    exp_pc = (mb[5] & zero) | (mb[6] & ~zero);
    check("pc_src", 32'(bus.out_pc_src), 32'(exp_pc));
    check("pc_branch", bus.out_pc_branch, pcb);
    check("debug_data", debug_data, model_load(32'(dbg) * 4, 2'b11, 1'b1));
    if (rst) begin
      e = '{32'h0, 32'h0, 5'h0, 2'h0, 1'b0};
    end else begin
      e.mem_data = mb[0] ? model_load(alu, mb[3:2], mb[4]) : 32'h0;
      e.alu  = alu;
      e.wreg = wreg;
      e.wb   = wb;
      e.halt = halt;
      if (mb[1]) model_store(alu, reg2, mb[3:2]);
    end
    sbq.push_back(e);
  endtask

  task automatic op(input logic [31:0] alu, input logic [31:0] reg2, input logic [8:0] mb);
    drive(1'b0, alu, reg2, mb, 2'b01, 5'd3, 1'b0, 1'b0, 32'h100, 10'd4);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("mem_data", bus.out_mem_data, e.mem_data);
        check("alu", bus.out_alu, e.alu);
        check("write_reg", 32'(bus.out_write_reg), 32'(e.wreg));
        check("wb_bus", 32'(bus.writeBack_bus_out), 32'(e.wb));
        check("halt", 32'(bus.out_halt_flag), 32'(e.halt));
      end
    end
  end

  initial begin : stim
    for (int i = 0; i < DEPTH*4; i++) model_mem[i] = 8'h00;
    reset = 1'b1;
    bus.in_alu = '0; bus.in_reg2 = '0; bus.memory_bus = '0; bus.writeBack_bus = '0;
    bus.in_write_reg = '0; bus.in_halt_flag = 1'b0; bus.in_zero_flag = 1'b0;
    bus.in_pc_branch = '0; debug_addr = '0;

    repeat (2) drive(1'b1, 32'h0, 32'h0, 9'h0, 2'b00, 5'd0, 1'b0, 1'b0, 32'h0, 10'd0);
    for (int w = 0; w < WORDS; w++) op(32'(w*4), 32'h0, 9'h00E);

    // word, byte, half accesses (mb: [0]rd [1]wr [3:2]size [4]uns)
    op(32'h10, 32'hDEADBEEF, 9'h00E);
    op(32'h10, 32'h0, 9'h00D);
    op(32'h21, 32'h123456AA, 9'h002);
    op(32'h21, 32'h0, 9'h001);
    op(32'h21, 32'h0, 9'h011);
    op(32'h20, 32'h0, 9'h00D);
    op(32'h32, 32'h00008001, 9'h006);
    op(32'h32, 32'h0, 9'h005);
    op(32'h32, 32'h0, 9'h015);
    op(32'h33, 32'hFFFF1234, 9'h006);
    op(32'h30, 32'h0, 9'h015);
    op(32'h3C, 32'h11223344, 9'h00A);
    op(32'h3C, 32'h55667788, 9'h00F);
    op(32'h3C, 32'h0, 9'h00D);
    op(32'hFFFF_F010, 32'h0, 9'h18D);

    // branch decisions
    drive(1'b0, 32'h0, 32'h0, 9'h020, 2'b00, 5'd0, 1'b0, 1'b1, 32'h400, 10'd4);
    drive(1'b0, 32'h0, 32'h0, 9'h020, 2'b00, 5'd0, 1'b0, 1'b0, 32'h404, 10'd4);
    drive(1'b0, 32'h0, 32'h0, 9'h040, 2'b00, 5'd0, 1'b0, 1'b1, 32'h408, 10'd4);
    drive(1'b0, 32'h0, 32'h0, 9'h040, 2'b00, 5'd0, 1'b0, 1'b0, 32'h40C, 10'd4);
    drive(1'b0, 32'h0, 32'h0, 9'h000, 2'b00, 5'd0, 1'b0, 1'b1, 32'h410, 10'd4);

    // pass-through, halt with store, reset mid-stream
    drive(1'b0, 32'h1234, 32'h0, 9'h000, 2'b01, 5'd9, 1'b0, 1'b0, 32'h0, 10'd4);
    drive(1'b0, 32'h44, 32'hA5A5A5A5, 9'h00E, 2'b11, 5'd31, 1'b1, 1'b0, 32'h0, 10'd17);
    drive(1'b1, 32'h40, 32'hCAFEF00D, 9'h00E, 2'b01, 5'd7, 1'b1, 1'b0, 32'h0, 10'd16);
    op(32'h40, 32'h0, 9'h00D);
    op(32'h10, 32'h0, 9'h00D);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = {$urandom_range(0, 32'hFFFFF), 4'h0, 8'($urandom)};
      drive(($urandom_range(0, 31) == 0), a, $urandom, 9'($urandom), 2'($urandom),
            5'($urandom), 1'($urandom), 1'($urandom), $urandom,
            NA'($urandom_range(0, WORDS-1)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
